fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Fetch stage and IF/ID pipeline register of the 5-stage pipeline. It is the producer side of the decode-stage interface (instrOut/nextPcOut).
- Owns the PC and drives the instruction-memory request/done handshake.
- Buffers a returned instruction while decode is stalled.
- Inserts NOP bubbles on memory wait, branch flush and halt.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset.
NOP_INSTR, 16'h0800, encoding driven on instrOut when no valid instruction is present.
PC_INC, 2, byte increment per instruction.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low.
stall  input  1  decode stall; hold the IF/ID register and the PC.
doBranch  input  1  redirect request from execute; flushes IF/ID.
branchTarget  input  16  redirect PC, valid with doBranch.
halt  input  1  halt retired downstream; stop fetching permanently.
imemAddr  output  16  instruction memory address.
imemRd  output  1  read request, held high until imemDone.
imemData  input  16  read data, valid when imemDone=1.
imemDone  input  1  read completion; may arrive the same cycle as imemRd, or later.
imemErr  input  1  access error, valid with imemDone.
instrOut  output  16  IF/ID instruction.
nextPcOut  output  16  IF/ID PC+PC_INC of instrOut.
err  output  1  IF/ID error flag for instrOut.

Behaviour:
Reset (rst=0, async):
- pc=RESET_PC; state=REQ.
- instrOut=NOP_INSTR, nextPcOut=0, err=0.
- Buffer cleared; haltPend=0.

Memory outputs:
- imemRd=1 in REQ and DRAIN; 0 in HOLD and HALTED.
- imemAddr=pc in REQ, address of the outstanding access in DRAIN, pc otherwise.

REQ:
- imemDone=1 & ~stall: IF/ID <= {imemData, pc+PC_INC, imemErr}; pc += PC_INC; stay in REQ. Back-to-back fetch gives 1 instr/cycle on zero-wait memory.
- imemDone=1 & stall: buf <= {imemData, pc+PC_INC, imemErr}; IF/ID held; pc += PC_INC; go to HOLD.
- imemDone=0 & ~stall: IF/ID <= {NOP_INSTR, 0, 0} (bubble).
- imemDone=0 & stall: IF/ID held.

HOLD:
- ~stall: IF/ID <= buf; go to REQ.
- stall: hold everything.

Redirect (doBranch=1; priority over stall, below halt and reset):
- IF/ID <= NOP_INSTR/0/0 regardless of stall; buf discarded; pc <= branchTarget.
- From REQ with imemDone=0: go to DRAIN. The old request stays asserted at the old address until imemDone, then its data is discarded and state goes to REQ.
- From REQ with imemDone=1 (same cycle): data discarded; stay in REQ.
- From HOLD: go to REQ.
- From DRAIN: latest branchTarget wins.

Halt (halt=1):
- Takes priority over doBranch.
- IF/ID <= NOP; buf discarded; pc frozen.
- No access outstanding: go to HALTED.
- Access outstanding: set haltPend and go to DRAIN; on imemDone go to HALTED.
- HALTED: imemRd=0, IF/ID=NOP; exits only on reset.

Arithmetic and protocol rules:
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000.
- imemRd never deasserts before imemDone.
- No new address is issued while an access is outstanding.

Test Plan:
- Zero-wait memory, imemDone tied to imemRd, words A,B,C from 0 -> instrOut A,B,C on consecutive cycles; nextPcOut 2,4,6; err=0.
- 2-cycle memory latency, no stall -> one NOP_INSTR bubble between each instruction; pc increments only on imemDone.
- Stall asserted for 3 cycles as word at 0x10 returns -> instrOut holds its prior value; after release instrOut = word@0x10 with nextPcOut=0x12, no duplicate and no loss.
- doBranch to 0x40 while an access to 0x08 is pending (done 2 cycles later) -> instrOut=NOP at once; imemAddr stays 0x08 until done; data@0x08 never appears; next request is to 0x40.
- halt with doBranch in the same cycle -> HALTED; imemRd=0 permanently; instrOut=NOP_INSTR; async rst low mid-stall -> outputs immediately return to reset values.
- pc=0xFFFE fetch -> nextPcOut=0x0000 and next imemAddr=0x0000; imemErr=1 on that fetch -> err=1 with that instruction, cleared by the following flush.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, runs the imem
// request/done handshake and inserts NOP bubbles on wait, redirect and halt.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [15:0] PC_INC    = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        doBranch,
    input  logic [15:0] branchTarget,
    input  logic        halt,
    output logic [15:0] imemAddr,
    output logic        imemRd,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    input  logic        imemErr,
    output logic [15:0] instrOut,
    output logic [15:0] nextPcOut,
    output logic        err
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] next_pc;
        logic        err;
    } ifid_t;

    localparam ifid_t NOP_ENTRY = '{instr: NOP_INSTR, next_pc: 16'h0000, err: 1'b0};

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    ifid_t       r_ifid, w_ifid_nxt;
    ifid_t       r_buf, w_buf_nxt;
    logic [15:0] r_drain_addr, w_drain_addr_nxt;
    logic        r_halt_pend, w_halt_pend_nxt;

    logic [15:0] w_pc_inc;
    ifid_t       w_fetched;

    assign w_pc_inc  = r_pc + PC_INC;
    assign w_fetched = '{instr: imemData, next_pc: w_pc_inc, err: imemErr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_ifid       <= NOP_ENTRY;
            r_buf        <= NOP_ENTRY;
            r_drain_addr <= RESET_PC;
            r_halt_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid       <= w_ifid_nxt;
            r_buf        <= w_buf_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_nxt       = r_ifid;
        w_buf_nxt        = r_buf;
        w_drain_addr_nxt = r_drain_addr;
        w_halt_pend_nxt  = r_halt_pend;

        case (r_state)
            S_REQ: begin
                if (halt) begin
                    w_ifid_nxt = NOP_ENTRY;
                    w_buf_nxt  = NOP_ENTRY;
                    if (imemDone) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_addr_nxt = r_pc;
                        w_halt_pend_nxt  = 1'b1;
                    end
                end else if (doBranch) begin
                    w_ifid_nxt = NOP_ENTRY;
                    w_buf_nxt  = NOP_ENTRY;
                    w_pc_nxt   = branchTarget;
                    // the in-flight access must finish at its old address
                    if (!imemDone) begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_addr_nxt = r_pc;
                    end
                end else if (imemDone) begin
                    w_pc_nxt = w_pc_inc;
                    if (stall) begin
                        w_buf_nxt   = w_fetched;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_ifid_nxt = w_fetched;
                    end
                end else if (!stall) begin
                    w_ifid_nxt = NOP_ENTRY;
                end
            end

            S_HOLD: begin
                if (halt) begin
                    w_ifid_nxt  = NOP_ENTRY;
                    w_buf_nxt   = NOP_ENTRY;
                    w_state_nxt = S_HALTED;
                end else if (doBranch) begin
                    w_ifid_nxt  = NOP_ENTRY;
                    w_buf_nxt   = NOP_ENTRY;
                    w_pc_nxt    = branchTarget;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_ifid_nxt  = r_buf;
                    w_buf_nxt   = NOP_ENTRY;
                    w_state_nxt = S_REQ;
                end
            end

            S_DRAIN: begin
                // returning data belongs to a squashed fetch; IF/ID stays empty
                w_ifid_nxt = NOP_ENTRY;
                if (halt) begin
                    w_halt_pend_nxt = 1'b1;
                end else if (doBranch && !r_halt_pend) begin
                    w_pc_nxt = branchTarget;
                end
                if (imemDone) begin
                    w_state_nxt = (halt || r_halt_pend) ? S_HALTED : S_REQ;
                end
            end

            default: begin
                w_ifid_nxt      = NOP_ENTRY;
                w_buf_nxt       = NOP_ENTRY;
                w_halt_pend_nxt = 1'b0;
                w_state_nxt     = S_HALTED;
            end
        endcase
    end

    assign imemRd    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imemAddr  = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign instrOut  = r_ifid.instr;
    assign nextPcOut = r_ifid.next_pc;
    assign err       = r_ifid.err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction memory with settable
// latency (data = addr + 0x1000) and an optional error address.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        doBranch;
    logic [15:0] branchTarget;
    logic        halt;
    logic [15:0] imemAddr;
    logic        imemRd;
    logic [15:0] imemData;
    logic        imemDone;
    logic        imemErr;
    logic [15:0] instrOut;
    logic [15:0] nextPcOut;
    logic        err;

    int          lat;
    int          wait_cnt;
    logic        err_en;
    logic [15:0] err_addr;
    int          n_chk;
    int          n_pass;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .doBranch    (doBranch),
        .branchTarget(branchTarget),
        .halt        (halt),
        .imemAddr    (imemAddr),
        .imemRd      (imemRd),
        .imemData    (imemData),
        .imemDone    (imemDone),
        .imemErr     (imemErr),
        .instrOut    (instrOut),
        .nextPcOut   (nextPcOut),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst)                      wait_cnt <= 0;
        else if (imemRd && !imemDone)  wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    assign imemDone = imemRd && (wait_cnt >= lat);
    assign imemData = imemAddr + 16'h1000;
    assign imemErr  = imemDone && err_en && (imemAddr == err_addr);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; stall = 1'b0; doBranch = 1'b0; branchTarget = 16'h0;
        halt = 1'b0; lat = 0; err_en = 1'b0; err_addr = 16'h0;
        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_instr", instrOut, 16'h0800);
        chk("rst_npc", nextPcOut, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'h0000);
        chk("rst_addr", imemAddr, 16'h0000);
        chk("rst_rd", {15'd0, imemRd}, 16'h0001);

        // zero-wait back-to-back
        rst = 1'b1;
        tick(); chk("zw_a", instrOut, 16'h1000); chk("zw_a_npc", nextPcOut, 16'h0002);
        tick(); chk("zw_b", instrOut, 16'h1002); chk("zw_b_npc", nextPcOut, 16'h0004);
        tick(); chk("zw_c", instrOut, 16'h1004); chk("zw_c_npc", nextPcOut, 16'h0006);
        chk("zw_err", {15'd0, err}, 16'h0000);

        // 2-cycle latency: bubble between instructions
        lat = 1;
        tick(); chk("l2_bub", instrOut, 16'h0800); chk("l2_addr", imemAddr, 16'h0006);
        tick(); chk("l2_d", instrOut, 16'h1006); chk("l2_d_npc", nextPcOut, 16'h0008);
        tick(); chk("l2_bub2", instrOut, 16'h0800);
        tick(); chk("l2_e", instrOut, 16'h1008); chk("l2_e_npc", nextPcOut, 16'h000A);
        for (int i = 0; i < 3; i++) begin tick(); tick(); end
        chk("l2_h", instrOut, 16'h100E);

        // stall for 3 cycles as word@0x10 returns
        lat = 0; stall = 1'b1;
        tick(); chk("st_hold0", instrOut, 16'h100E); chk("st_rd", {15'd0, imemRd}, 16'h0000);
        tick(); chk("st_hold1", instrOut, 16'h100E);
        tick(); chk("st_hold2", instrOut, 16'h100E);
        stall = 1'b0;
        tick(); chk("st_rel", instrOut, 16'h1010); chk("st_rel_npc", nextPcOut, 16'h0012);
        tick(); chk("st_next", instrOut, 16'h1012); chk("st_next_npc", nextPcOut, 16'h0014);

        // branch on a same-cycle completion, then redirect while 0x08 pending
        doBranch = 1'b1; branchTarget = 16'h0008;
        tick(); chk("br0_nop", instrOut, 16'h0800); chk("br0_addr", imemAddr, 16'h0008);
        doBranch = 1'b0; lat = 3;
        tick();
        doBranch = 1'b1; branchTarget = 16'h0040;
        tick(); chk("br_nop", instrOut, 16'h0800); chk("br_drain_addr", imemAddr, 16'h0008);
        chk("br_drain_rd", {15'd0, imemRd}, 16'h0001);
        doBranch = 1'b0;
        tick(); chk("br_drain_addr2", imemAddr, 16'h0008);
        tick(); chk("br_discard", instrOut, 16'h0800); chk("br_new_addr", imemAddr, 16'h0040);
        lat = 0;
        tick(); chk("br_tgt", instrOut, 16'h1040); chk("br_tgt_npc", nextPcOut, 16'h0042);

        // PC wrap with error flag, cleared by following flush
        doBranch = 1'b1; branchTarget = 16'hFFFE;
        tick();
        doBranch = 1'b0; err_en = 1'b1; err_addr = 16'hFFFE;
        tick(); chk("wr_instr", instrOut, 16'h0FFE); chk("wr_npc", nextPcOut, 16'h0000);
        chk("wr_err", {15'd0, err}, 16'h0001); chk("wr_addr", imemAddr, 16'h0000);
        doBranch = 1'b1; branchTarget = 16'h0020;
        tick(); chk("fl_err", {15'd0, err}, 16'h0000); chk("fl_nop", instrOut, 16'h0800);
        doBranch = 1'b0; err_en = 1'b0;

        // halt and branch together with an access outstanding
        lat = 2; halt = 1'b1; doBranch = 1'b1; branchTarget = 16'h0080;
        tick(); chk("hl_rd", {15'd0, imemRd}, 16'h0001); chk("hl_addr", imemAddr, 16'h0020);
        chk("hl_nop", instrOut, 16'h0800);
        halt = 1'b0; doBranch = 1'b0;
        tick(); tick();
        chk("hl_rd0", {15'd0, imemRd}, 16'h0000); chk("hl_pc", imemAddr, 16'h0020);
        doBranch = 1'b1; lat = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("hl_stay_rd", {15'd0, imemRd}, 16'h0000); chk("hl_stay_nop", instrOut, 16'h0800);
        doBranch = 1'b0;

        // async reset mid-stall
        rst = 1'b0; #2 rst = 1'b1;
        tick(); chk("rs_fetch", instrOut, 16'h1000);
        stall = 1'b1;
        tick(); chk("rs_hold", instrOut, 16'h1000);
        #2 rst = 1'b0;
        #1;
        chk("ar_instr", instrOut, 16'h0800); chk("ar_npc", nextPcOut, 16'h0000);
        chk("ar_rd", {15'd0, imemRd}, 16'h0001); chk("ar_addr", imemAddr, 16'h0000);
        rst = 1'b1; stall = 1'b0;
        tick(); chk("ar_refetch", instrOut, 16'h1000); chk("ar_refetch_npc", nextPcOut, 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
